// File: rtl/rx_pkg.sv
// Shared types for the serial receive framer: FSM state encoding and
// parity-type constants used by the framer and its parity helper.
package rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage : rx_pkg

// File: rtl/rx_parity_calc.sv
// Combinational expected-parity generator: the parity bit a correct
// transmitter would append to data_i for the selected parity type.
module rx_parity_calc
    import rx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic              par_typ_i,
    output logic              exp_par_o
);

    logic data_xor;

    always_comb begin
        data_xor  = ^data_i;
        exp_par_o = (par_typ_i == PAR_ODD) ? ~data_xor : data_xor;
    end

endmodule : rx_parity_calc

// File: rtl/rx_shift_framer.sv
// Serial-to-parallel receive framer: collects DATA_W strobed bits plus an
// optional parity bit, then presents the frame with a one-cycle valid pulse.
module rx_shift_framer
    import rx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              deser_en,
    input  logic              sampled_bit,
    input  logic              par_en,
    input  logic              par_typ,
    output logic [DATA_W-1:0] p_data,
    output logic              data_valid,
    output logic              par_err,
    output logic              busy
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [DATA_W-1:0] p_data_q, p_data_d;
    logic              par_err_q, par_err_d;
    logic              par_en_q, par_en_d;
    logic              par_typ_q, par_typ_d;
    logic              strobe_data;
    logic              frame_done;
    logic              exp_par;

    // New bit enters at the end that ends up holding the last-received bit.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sr,
                                                   input logic              b);
        if (LSB_FIRST)
            return {b, sr[DATA_W-1:1]};
        else
            return {sr[DATA_W-2:0], b};
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; start overrides everything, including DONE
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_DATA;
        end else begin
            unique case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_DATA: begin
                    if (deser_en && (cnt_q == CNT_LAST))
                        state_d = par_en_q ? ST_PARITY : ST_DONE;
                end
                ST_PARITY: begin
                    if (deser_en)
                        state_d = ST_DONE;
                end
                ST_DONE:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        busy       = (state_q == ST_DATA) || (state_q == ST_PARITY);
        data_valid = (state_q == ST_DONE);
    end

    always_comb begin
        strobe_data = !start && deser_en && (state_q == ST_DATA);
        frame_done  = (state_d == ST_DONE);

        cnt_d     = cnt_q;
        sr_d      = sr_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        p_data_d  = p_data_q;
        par_err_d = par_err_q;

        if (start) begin
            cnt_d     = '0;
            sr_d      = '0;
            par_en_d  = par_en;
            par_typ_d = par_typ;
        end else if (strobe_data) begin
            if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + CNT_W'(1);
            sr_d = shift_in(sr_q, sampled_bit);
        end

        // sr_d already holds the final data bit on the completing edge; in the
        // parity case the strobed bit is the received parity.
        if (frame_done) begin
            p_data_d  = sr_d;
            par_err_d = par_en_q & (sampled_bit ^ exp_par);
        end
    end

    rx_parity_calc #(
        .DATA_W (DATA_W)
    ) u_parity (
        .data_i    (sr_d),
        .par_typ_i (par_typ_q),
        .exp_par_o (exp_par)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            sr_q      <= '0;
            p_data_q  <= '0;
            par_err_q <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            p_data_q  <= p_data_d;
            par_err_q <= par_err_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
        end
    end

    assign p_data  = p_data_q;
    assign par_err = par_err_q;

endmodule : rx_shift_framer

// File: doc/rx_shift_framer.md
RX_SHIFT_FRAMER -- requirements
Module: rx_shift_framer

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-002 Parameter LSB_FIRST, default 1, 1 = first received bit is p_data[0]; 0 = first received bit is p_data[DATA_W-1].
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse: begin a new frame.
REQ-006 deser_en  input  1  bit strobe: sampled_bit is valid this cycle.
REQ-007 sampled_bit  input  1  recovered serial bit.
REQ-008 par_en  input  1  1 = a parity bit follows the data bits.
REQ-009 par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-010 p_data  output  DATA_W  last completed frame, held until the next completion.
REQ-011 data_valid  output  1  one-cycle pulse on frame completion.
REQ-012 par_err  output  1  parity result of the last completed frame, valid with and after data_valid.
REQ-013 busy  output  1  high while a frame is in progress.

Function
REQ-014 FSM states: IDLE, DATA, PARITY, DONE.
- IDLE->DATA on start.
- DATA->PARITY after the DATA_W-th strobe when par_en=1.
- DATA->DONE after the DATA_W-th strobe when par_en=0.
- PARITY->DONE on the next strobe.
- DONE->IDLE unconditionally after one cycle.
REQ-015 On start, clear the bit counter and the working shift register, and latch par_en and par_typ for the whole frame.
REQ-016 In DATA, each deser_en cycle shifts sampled_bit into the working register and increments the counter.
- LSB_FIRST=1: shift right, new bit enters the MSB.
- LSB_FIRST=0: shift left, new bit enters the LSB.
REQ-017 Bit counter width is clog2(DATA_W+1); counter saturates at DATA_W and never wraps.
REQ-018 In PARITY, the strobe captures sampled_bit as the received parity bit.
REQ-019 Parity check:
- Even: par_err=1 when received parity != XOR of the data bits.
- Odd: par_err=1 when received parity != XNOR of the data bits.
- par_en=0: par_err=0.
REQ-020 On the DONE cycle, data_valid=1 and p_data and par_err update. data_valid occurs exactly one cycle after the final strobe.
REQ-021 deser_en in IDLE or DONE is ignored.
REQ-022 start in any state, including DONE, aborts the current frame and restarts at DATA. An aborted frame produces no data_valid, and p_data/par_err are unchanged.
REQ-023 start and deser_en in the same cycle: start wins; that strobe's bit is discarded.
REQ-024 busy=1 in DATA and PARITY; busy=0 in IDLE and DONE.
REQ-025 Changes to par_en or par_typ mid-frame have no effect.

Reset
REQ-026 rst_n low asynchronously forces IDLE, and clears the counter, working register, p_data, data_valid, par_err and busy to 0.
REQ-027 Reset asserted mid-frame discards the frame with no data_valid. After release the block waits for start.

Structure
REQ-028 A shared package rx_pkg holds the FSM state enum and the parity-type constants (PAR_EVEN=0, PAR_ODD=1).
REQ-029 One sub-module, rx_parity_calc, is natural: combinational, DATA_W-parameterised; inputs data and par_typ; output expected parity bit.

Verification
REQ-030 DATA_W=8, LSB_FIRST=1, par_en=0; start, then bits 1,0,1,0,0,1,0,1 -> p_data=0xA5, data_valid high exactly one cycle after the 8th strobe, par_err=0.
REQ-031 DATA_W=8, LSB_FIRST=0, same bit sequence -> p_data=0xA5 (sequence is a palindrome); then bits 1,1,0,0,0,0,0,0 -> p_data=0xC0.
REQ-032 par_en=1, even parity, data 0xA5:
- parity bit 0 -> par_err=0.
- parity bit 1 -> par_err=1.
- With odd parity, parity bit 1 -> par_err=0.
REQ-033 start after 4 data bits, then a full 0x3C frame -> single data_valid, p_data=0x3C; start+deser_en in the same cycle -> that bit is absent from the result.
REQ-034 rst_n pulsed low after 5 bits -> all outputs 0 immediately; no data_valid; a subsequent frame 0x5A completes correctly.
REQ-035 DATA_W=5 and DATA_W=9 builds: one frame each -> correct p_data, with data_valid after exactly DATA_W strobes.
